// File: rtl/wrr_req_tracker.sv
// wrr_req_tracker: per-client pending counters feeding a WRR arbiter, acking valid grants into a registered ID stream
module wrr_req_tracker #(
  parameter int N       = 32,
  parameter int ID_BITS = $clog2(N),
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       push_vld,
  output logic [N-1:0]       push_rdy,
  output logic [N-1:0]       req,
  input  logic [N-1:0]       gnt_w,
  input  logic [ID_BITS-1:0] gnt_id,
  output logic               ack,
  output logic               out_vld,
  output logic [ID_BITS-1:0] out_id,
  input  logic               out_rdy,
  output logic               err
);
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0] push, dec;
  logic free, one_hot, gnt_ok;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      push_rdy[i] = cnt[i] != '1;
      req[i]      = |cnt[i];
    end
  end
  assign free    = ~out_vld | out_rdy;
  assign one_hot = |gnt_w && ((gnt_w & (gnt_w - 1'b1)) == '0);
  assign gnt_ok  = one_hot && gnt_w[gnt_id] && req[gnt_id];
  assign ack     = gnt_ok & free;
  assign push    = push_vld & push_rdy;
  // gnt_w is one-hot at gnt_id whenever ack is high, so it doubles as the decrement mask
  assign dec     = {N{ack}} & gnt_w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (push[i] & ~dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] & ~push[i]) cnt[i] <= cnt[i] - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_id  <= '0;
      err     <= 1'b0;
    end else begin
      if (ack) begin
        out_vld <= 1'b1;
        out_id  <= gnt_id;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
      if (|gnt_w && !gnt_ok) err <= 1'b1;
    end
  end
endmodule
